// File: rtl/lfsr_fault_injector.sv
//==============================================================================
// Module: lfsr_fault_injector
//
// Purpose
//   Fault injector that sits between a valid/ready data source and the
//   protected unit under test. Every Nth accepted beat, the pseudo-random mask
//   from an upstream LFSR is shaped into a fault mask and XORed into that beat.
//   The datapath is a single registered pipeline stage with full throughput.
//   After each injection slot the block spends one cycle in ADVANCE. During
//   that cycle it pulses o_lfsr_enable so that the LFSR presents a fresh mask
//   for the next injection.
//
// Parameters
//   DATA_W    data width, at most 32 (mask bits [DATA_W-1:0] are used)
//   PERIOD_W  width of i_cfg_period and the internal beat counter
//   CNT_W     width of o_fault_count
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_cfg_enable   1 = injection armed, 0 = pure pass-through
//   i_cfg_mode     00 off, 01 single-bit, 10 sparse, 11 full mask
//   i_cfg_period   inject on every Nth accepted beat (0 behaves as 1)
//   i_lfsr_mask    pseudo-random mask from the LFSR
//   o_lfsr_enable  one-cycle pulse asking the LFSR to advance
//   i_s_valid      upstream beat valid
//   o_s_ready      upstream beat accepted when i_s_valid & o_s_ready
//   i_s_data       upstream data
//   o_m_valid      downstream beat valid
//   i_m_ready      downstream accept
//   o_m_data       registered i_s_data XOR fault mask
//   o_m_fault      1 when the current o_m_data beat carries a nonzero mask
//   o_fault_count  corrupted beats since reset, saturating at all-ones
//==============================================================================
module lfsr_fault_injector #(
    parameter int DATA_W   = 32,
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cfg_enable,
    input  logic [1:0]          i_cfg_mode,
    input  logic [PERIOD_W-1:0] i_cfg_period,
    input  logic [31:0]         i_lfsr_mask,
    output logic                o_lfsr_enable,
    input  logic                i_s_valid,
    output logic                o_s_ready,
    input  logic [DATA_W-1:0]   i_s_data,
    output logic                o_m_valid,
    input  logic                i_m_ready,
    output logic [DATA_W-1:0]   o_m_data,
    output logic                o_m_fault,
    output logic [CNT_W-1:0]    o_fault_count
);

    // Width of the bit index used by single-bit mode. The minimum is 1, so
    // that a 1-bit datapath still has a legal slice.
    localparam int          IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [31:0] DATA_W_U = DATA_W;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_SPARSE = 2'b10;
    localparam logic [1:0] MODE_FULL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_ADVANCE = 2'b10
    } state_e;

    state_e                r_state;
    state_e                w_stateNext;
    logic [PERIOD_W-1:0]   r_beatCnt;
    logic [PERIOD_W-1:0]   w_beatCntNext;

    logic                  r_mValid;
    logic [DATA_W-1:0]     r_mData;
    logic                  r_mFault;
    logic [CNT_W-1:0]      r_faultCount;

    logic                  w_enabled;
    logic                  w_accept;
    logic                  w_hit;
    logic [PERIOD_W-1:0]   w_periodLast;
    logic [DATA_W-1:0]     w_mask;
    logic [IDX_W-1:0]      w_bitIdx;
    logic [DATA_W-1:0]     w_oneHot;
    logic [DATA_W-1:0]     w_sparse;
    logic [DATA_W-1:0]     w_faultMask;
    logic [DATA_W-1:0]     w_appliedMask;

    // Injection is live only with the enable set and a non-off mode. Either
    // condition dropping sends the FSM back to IDLE.
    assign w_enabled = i_cfg_enable & (i_cfg_mode != MODE_OFF);

    // The upstream side is accepted whenever the output register is free or
    // being drained. The exception is the ADVANCE cycle, which is reserved
    // for the LFSR to step, so the stream pauses for that one cycle.
    assign o_s_ready = (r_state != ST_ADVANCE) & (~r_mValid | i_m_ready);
    assign w_accept  = i_s_valid & o_s_ready;

    // A period of 0 behaves the same as a period of 1, which injects every beat.
    assign w_periodLast = (i_cfg_period == '0) ? '0 : (i_cfg_period - PERIOD_W'(1));

    // The compare is >= so that a period shortened below the current count
    // takes effect on the very next accepted beat.
    assign w_hit = (r_state == ST_ARMED) & w_enabled & w_accept
                 & (r_beatCnt >= w_periodLast);

    // Candidate masks, all derived from the LFSR word present on the accept
    // cycle. The modulo is a no-op for power-of-two widths.
    assign w_mask   = i_lfsr_mask[DATA_W-1:0];
    assign w_bitIdx = IDX_W'(32'(i_lfsr_mask[IDX_W-1:0]) % DATA_W_U);
    assign w_oneHot = DATA_W'(1) << w_bitIdx;
    assign w_sparse = w_mask & ~(w_mask >> 1);

    // Select the shaped mask for the configured mode. Off mode never corrupts.
    always_comb begin
        w_faultMask = '0;
        case (i_cfg_mode)
            MODE_SINGLE: w_faultMask = w_oneHot;
            MODE_SPARSE: w_faultMask = w_sparse;
            MODE_FULL:   w_faultMask = w_mask;
            default:     w_faultMask = '0;
        endcase
    end

    // Only the injection beat sees the mask. Every other beat passes untouched.
    assign w_appliedMask = w_hit ? w_faultMask : '0;

    // FSM next-state and beat counter update.
    // In IDLE the counter is held at zero so that arming always starts a fresh
    // period. In ARMED the counter only moves on accepted beats, so stalls
    // freeze it. ADVANCE always lasts exactly one cycle.
    always_comb begin
        w_stateNext   = r_state;
        w_beatCntNext = r_beatCnt;
        case (r_state)
            ST_IDLE: begin
                w_beatCntNext = '0;
                if (w_enabled) begin
                    w_stateNext = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!w_enabled) begin
                    w_stateNext   = ST_IDLE;
                    w_beatCntNext = '0;
                end else if (w_accept) begin
                    if (w_hit) begin
                        w_stateNext   = ST_ADVANCE;
                        w_beatCntNext = '0;
                    end else begin
                        w_beatCntNext = r_beatCnt + PERIOD_W'(1);
                    end
                end
            end
            ST_ADVANCE: begin
                w_beatCntNext = '0;
                w_stateNext   = w_enabled ? ST_ARMED : ST_IDLE;
            end
            default: begin
                w_stateNext   = ST_IDLE;
                w_beatCntNext = '0;
            end
        endcase
    end

    // State register and beat counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_beatCnt <= w_beatCntNext;
        end
    end

    // Output pipeline register.
    // A new beat loads on accept. Without an accept, a downstream handshake
    // empties the stage. The fault flag is cleared together with valid, so it
    // can never be seen on an empty stage. While stalled, everything holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mValid <= 1'b0;
            r_mData  <= '0;
            r_mFault <= 1'b0;
        end else if (w_accept) begin
            r_mValid <= 1'b1;
            r_mData  <= i_s_data ^ w_appliedMask;
            r_mFault <= |w_appliedMask;
        end else if (i_m_ready) begin
            r_mValid <= 1'b0;
            r_mFault <= 1'b0;
        end
    end

    // Count of beats that were actually corrupted.
    // An injection slot with an all-zero mask still uses up its slot but does
    // not count. The counter sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_faultCount <= '0;
        end else if (w_hit && (|w_faultMask) && (r_faultCount != '1)) begin
            r_faultCount <= r_faultCount + CNT_W'(1);
        end
    end

    // The LFSR step request comes straight from the ADVANCE state. It is
    // masked by reset, so a reset that lands in that cycle does not let a
    // pulse escape.
    assign o_lfsr_enable = (r_state == ST_ADVANCE) & ~i_rst;

    assign o_m_valid     = r_mValid;
    assign o_m_data      = r_mData;
    assign o_m_fault     = r_mFault;
    assign o_fault_count = r_faultCount;

endmodule

// File: tb/tb_lfsr_fault_injector.sv
//==============================================================================
// Testbench: tb_lfsr_fault_injector
//
// Purpose
//   Directed self-checking bench for lfsr_fault_injector. Inputs change 1 ns
//   after the rising edge. Outputs are sampled 2 ns after the rising edge.
//   A second instance with CNT_W = 4 shares every input. Its counter is
//   checked only in the saturation scenario.
//==============================================================================
module tb_lfsr_fault_injector;

    logic        clk;
    logic        i_rst;
    logic        i_cfg_enable;
    logic [1:0]  i_cfg_mode;
    logic [15:0] i_cfg_period;
    logic [31:0] i_lfsr_mask;
    logic        i_s_valid;
    logic [31:0] i_s_data;
    logic        i_m_ready;

    logic        o_lfsr_enable;
    logic        o_s_ready;
    logic        o_m_valid;
    logic [31:0] o_m_data;
    logic        o_m_fault;
    logic [15:0] o_fault_count;

    logic        o4_lfsr_enable;
    logic        o4_s_ready;
    logic        o4_m_valid;
    logic [31:0] o4_m_data;
    logic        o4_m_fault;
    logic [3:0]  o4_fault_count;

    int compared;
    int mismatched;

    lfsr_fault_injector #(.DATA_W(32), .PERIOD_W(16), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_cfg_enable(i_cfg_enable),
        .i_cfg_mode(i_cfg_mode), .i_cfg_period(i_cfg_period),
        .i_lfsr_mask(i_lfsr_mask), .o_lfsr_enable(o_lfsr_enable),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
        .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data),
        .o_m_fault(o_m_fault), .o_fault_count(o_fault_count)
    );

    lfsr_fault_injector #(.DATA_W(32), .PERIOD_W(16), .CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst(i_rst), .i_cfg_enable(i_cfg_enable),
        .i_cfg_mode(i_cfg_mode), .i_cfg_period(i_cfg_period),
        .i_lfsr_mask(i_lfsr_mask), .o_lfsr_enable(o4_lfsr_enable),
        .i_s_valid(i_s_valid), .o_s_ready(o4_s_ready), .i_s_data(i_s_data),
        .o_m_valid(o4_m_valid), .i_m_ready(i_m_ready), .o_m_data(o4_m_data),
        .o_m_fault(o4_m_fault), .o_fault_count(o4_fault_count)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge, where every task expects to sit
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles with a valid beat offered must leave everything idle
    task automatic test_reset();
        $display("[TB] test_reset");
        i_rst = 1'b1;
        i_s_valid = 1'b1;
        i_s_data = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (o_m_valid !== 1'b0 || o_m_data !== 32'h0 || o_m_fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_out: got v=%b d=%h f=%b, want v=0 d=0 f=0", o_m_valid, o_m_data, o_m_fault);
        end
        compared++;
        if (o_lfsr_enable !== 1'b0 || o_fault_count !== 16'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctl: got en=%b cnt=%0d, want en=0 cnt=0", o_lfsr_enable, o_fault_count);
        end
        i_rst = 1'b0;
        i_s_valid = 1'b0;
    endtask

    // With enable low the full-mask mode is inert: data passes unchanged with latency 1
    task automatic test_pass_through();
        $display("[TB] test_pass_through");
        i_cfg_enable = 1'b0;
        i_cfg_mode = 2'b11;
        i_cfg_period = 16'd1;
        i_lfsr_mask = 32'hFFFF_FFFF;
        i_m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_s_valid = 1'b1;
            i_s_data = 32'(i);
            #1;
            compared++;
            if (o_s_ready !== 1'b1 || o_lfsr_enable !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL pass_ctl beat%0d: got rdy=%b en=%b, want rdy=1 en=0", i, o_s_ready, o_lfsr_enable);
            end
            if (i > 0) begin
                compared++;
                if (o_m_valid !== 1'b1 || o_m_data !== 32'(i - 1) || o_m_fault !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL pass_data beat%0d: got v=%b d=%h f=%b, want v=1 d=%h f=0", i - 1, o_m_valid, o_m_data, o_m_fault, 32'(i - 1));
                end
            end
            tick();
        end
        i_s_valid = 1'b0;
        #1;
        compared++;
        if (o_m_valid !== 1'b1 || o_m_data !== 32'h9 || o_m_fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL pass_last: got v=%b d=%h f=%b, want v=1 d=9 f=0", o_m_valid, o_m_data, o_m_fault);
        end
        tick();
    endtask

    // Table of mode/period/mask rows. Each row checks every output beat, the
    // LFSR pulse after every injection slot, and the fault count per row.
    task automatic test_mask_modes();
        logic [1:0]  mode;
        logic [15:0] period;
        logic [31:0] lmask, expMask, expData, data;
        logic [15:0] expCount;
        logic        pend, expFault, expAdv, inj;
        int          nBeats, perEff, acc, cyc;
        $display("[TB] test_mask_modes");
        expCount = 16'd0;
        i_m_ready = 1'b1;
        for (int row = 0; row < 4; row++) begin
            case (row)
                0:       begin mode = 2'b11; period = 16'd4; lmask = 32'h0000_00F0; expMask = 32'h0000_00F0; nBeats = 8; end
                1:       begin mode = 2'b01; period = 16'd0; lmask = 32'hABCD_0025; expMask = 32'h0000_0020; nBeats = 4; end
                2:       begin mode = 2'b10; period = 16'd2; lmask = 32'h0000_00F6; expMask = 32'h0000_0084; nBeats = 4; end
                default: begin mode = 2'b11; period = 16'd1; lmask = 32'h0000_0000; expMask = 32'h0000_0000; nBeats = 2; end
            endcase
            perEff = (period == 16'd0) ? 1 : int'(period);
            i_cfg_enable = 1'b1;
            i_cfg_mode = mode;
            i_cfg_period = period;
            i_lfsr_mask = lmask;
            i_s_valid = 1'b0;
            tick();
            acc = 0;
            cyc = 0;
            pend = 1'b0;
            expAdv = 1'b0;
            expData = 32'h0;
            expFault = 1'b0;
            while ((acc < nBeats || pend || expAdv) && cyc < 60) begin
                data = 32'h5A00_0000 | (32'(row) << 16) | (32'(acc) << 8);
                i_s_valid = (acc < nBeats);
                i_s_data = data;
                #1;
                compared++;
                if (pend) begin
                    if (o_m_valid !== 1'b1 || o_m_data !== expData || o_m_fault !== expFault) begin
                        mismatched++;
                        $display("[TB] FAIL modes_row%0d_data: got v=%b d=%h f=%b, want v=1 d=%h f=%b", row, o_m_valid, o_m_data, o_m_fault, expData, expFault);
                    end
                end else begin
                    if (o_m_valid !== 1'b0 || o_m_fault !== 1'b0) begin
                        mismatched++;
                        $display("[TB] FAIL modes_row%0d_idle: got v=%b f=%b, want v=0 f=0", row, o_m_valid, o_m_fault);
                    end
                end
                compared++;
                if (o_lfsr_enable !== expAdv || (expAdv && o_s_ready !== 1'b0)) begin
                    mismatched++;
                    $display("[TB] FAIL modes_row%0d_adv: got en=%b rdy=%b, want en=%b rdy=%b", row, o_lfsr_enable, o_s_ready, expAdv, ~expAdv);
                end
                pend = 1'b0;
                expAdv = 1'b0;
                if (i_s_valid && o_s_ready === 1'b1) begin
                    inj = ((acc % perEff) == (perEff - 1));
                    pend = 1'b1;
                    expData = data ^ (inj ? expMask : 32'h0);
                    expFault = inj && (expMask != 32'h0);
                    expAdv = inj;
                    if (expFault) expCount++;
                    acc++;
                end
                cyc++;
                tick();
            end
            compared++;
            if (acc != nBeats || o_fault_count !== expCount) begin
                mismatched++;
                $display("[TB] FAIL modes_row%0d_count: got beats=%0d cnt=%0d, want beats=%0d cnt=%0d", row, acc, o_fault_count, nBeats, expCount);
            end
        end
    endtask

    // Downstream stall: the output holds, upstream is blocked and the beat
    // counter freezes, so the third beat (not the second) takes the injection
    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        i_cfg_enable = 1'b1;
        i_cfg_mode = 2'b11;
        i_cfg_period = 16'd3;
        i_lfsr_mask = 32'h0000_000F;
        i_m_ready = 1'b1;
        i_s_valid = 1'b1;
        i_s_data = 32'h0000_0111;
        #1;
        compared++;
        if (o_s_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_first_ready: got %b, want 1", o_s_ready);
        end
        tick();
        i_m_ready = 1'b0;
        i_s_data = 32'h0000_0222;
        for (int i = 0; i < 5; i++) begin
            #1;
            compared++;
            if (o_m_valid !== 1'b1 || o_m_data !== 32'h111 || o_m_fault !== 1'b0 || o_s_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bp_hold cyc%0d: got v=%b d=%h f=%b rdy=%b, want v=1 d=111 f=0 rdy=0", i, o_m_valid, o_m_data, o_m_fault, o_s_ready);
            end
            tick();
        end
        i_m_ready = 1'b1;
        #1;
        compared++;
        if (o_s_ready !== 1'b1 || o_m_data !== 32'h111) begin
            mismatched++;
            $display("[TB] FAIL bp_release: got rdy=%b d=%h, want rdy=1 d=111", o_s_ready, o_m_data);
        end
        tick();
        i_s_data = 32'h0000_0333;
        #1;
        compared++;
        if (o_m_data !== 32'h222 || o_m_fault !== 1'b0 || o_s_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_second: got d=%h f=%b rdy=%b, want d=222 f=0 rdy=1", o_m_data, o_m_fault, o_s_ready);
        end
        tick();
        i_s_valid = 1'b0;
        #1;
        compared++;
        if (o_m_data !== 32'h33C || o_m_fault !== 1'b1 || o_lfsr_enable !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_inject: got d=%h f=%b en=%b, want d=33c f=1 en=1", o_m_data, o_m_fault, o_lfsr_enable);
        end
        compared++;
        if (o_fault_count !== 16'd9) begin
            mismatched++;
            $display("[TB] FAIL bp_count: got %0d, want 9", o_fault_count);
        end
        tick();
    endtask

    // Shrinking the period below the current count injects on the next beat.
    // Dropping the enable in ARMED passes the accepted beat through clean.
    task automatic test_period_change();
        $display("[TB] test_period_change");
        i_cfg_period = 16'd8;
        i_lfsr_mask = 32'h8000_0001;
        i_s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) i_cfg_period = 16'd3;
            i_s_data = 32'h100 + 32'(i);
            #1;
            compared++;
            if (o_s_ready !== 1'b1 || o_lfsr_enable !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL pc_ctl beat%0d: got rdy=%b en=%b, want rdy=1 en=0", i, o_s_ready, o_lfsr_enable);
            end
            if (i > 0) begin
                compared++;
                if (o_m_data !== (32'h100 + 32'(i - 1)) || o_m_fault !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL pc_clean beat%0d: got d=%h f=%b, want d=%h f=0", i - 1, o_m_data, o_m_fault, 32'h100 + 32'(i - 1));
                end
            end
            tick();
        end
        i_s_valid = 1'b0;
        #1;
        compared++;
        if (o_m_data !== 32'h8000_0104 || o_m_fault !== 1'b1 || o_lfsr_enable !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL pc_inject: got d=%h f=%b en=%b, want d=80000104 f=1 en=1", o_m_data, o_m_fault, o_lfsr_enable);
        end
        tick();
        i_cfg_period = 16'd0;
        i_cfg_enable = 1'b0;
        i_s_valid = 1'b1;
        i_s_data = 32'h0000_0077;
        tick();
        i_s_valid = 1'b0;
        #1;
        compared++;
        if (o_m_data !== 32'h77 || o_m_fault !== 1'b0 || o_lfsr_enable !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL pc_disable: got d=%h f=%b en=%b, want d=77 f=0 en=0", o_m_data, o_m_fault, o_lfsr_enable);
        end
        tick();
        compared++;
        if (o_lfsr_enable !== 1'b0 || o_fault_count !== 16'd10) begin
            mismatched++;
            $display("[TB] FAIL pc_after: got en=%b cnt=%0d, want en=0 cnt=10", o_lfsr_enable, o_fault_count);
        end
        tick();
    endtask

    // 20 injections saturate the 4-bit counter, then a reset lands on an accept
    task automatic test_saturation_reset();
        int acc;
        int cyc;
        $display("[TB] test_saturation_reset");
        i_rst = 1'b1;
        i_s_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        i_cfg_enable = 1'b1;
        i_cfg_mode = 2'b11;
        i_cfg_period = 16'd0;
        i_lfsr_mask = 32'h0000_0001;
        i_m_ready = 1'b1;
        tick();
        acc = 0;
        cyc = 0;
        while (acc < 20 && cyc < 100) begin
            i_s_valid = 1'b1;
            i_s_data = 32'(acc);
            #1;
            if (o_s_ready === 1'b1) acc++;
            cyc++;
            tick();
        end
        i_s_valid = 1'b0;
        #1;
        compared++;
        if (acc != 20 || o_fault_count !== 16'd20 || o_lfsr_enable !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sat_main: got beats=%0d cnt=%0d en=%b, want beats=20 cnt=20 en=1", acc, o_fault_count, o_lfsr_enable);
        end
        compared++;
        if (o4_fault_count !== 4'hF) begin
            mismatched++;
            $display("[TB] FAIL sat_cnt4: got %h, want f", o4_fault_count);
        end
        tick();
        i_cfg_period = 16'd100;
        i_s_valid = 1'b1;
        i_s_data = 32'h0000_00AA;
        tick();
        i_s_data = 32'h0000_00BB;
        i_rst = 1'b1;
        #1;
        compared++;
        if (o_m_valid !== 1'b1 || o_m_data !== 32'hAA) begin
            mismatched++;
            $display("[TB] FAIL rst_pre: got v=%b d=%h, want v=1 d=aa", o_m_valid, o_m_data);
        end
        tick();
        i_rst = 1'b0;
        i_s_valid = 1'b0;
        #1;
        compared++;
        if (o_m_valid !== 1'b0 || o_m_fault !== 1'b0 || o_m_data !== 32'h0 || o_lfsr_enable !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_out: got v=%b f=%b d=%h en=%b, want v=0 f=0 d=0 en=0", o_m_valid, o_m_fault, o_m_data, o_lfsr_enable);
        end
        compared++;
        if (o_fault_count !== 16'h0 || o4_fault_count !== 4'h0) begin
            mismatched++;
            $display("[TB] FAIL rst_count: got %0d/%0d, want 0/0", o_fault_count, o4_fault_count);
        end
        tick();
        compared++;
        if (o_lfsr_enable !== 1'b0 || o_m_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_after: got en=%b v=%b, want en=0 v=0", o_lfsr_enable, o_m_valid);
        end
        tick();
    endtask

    // Scenario sequence
    initial begin
        compared = 0;
        mismatched = 0;
        i_rst = 1'b1;
        i_cfg_enable = 1'b0;
        i_cfg_mode = 2'b00;
        i_cfg_period = 16'd0;
        i_lfsr_mask = 32'h0;
        i_s_valid = 1'b0;
        i_s_data = 32'h0;
        i_m_ready = 1'b1;
        test_reset();
        test_pass_through();
        test_mask_modes();
        test_backpressure();
        test_period_change();
        test_saturation_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time limit so that a wedged run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000 ns, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
